// File: rtl/snn_result_collector_if.sv
// Bus between the inference array / host and snn_result_collector:
// per-lane done/class levels, soft clear, and the FWFT result FIFO read port with status.
interface snn_result_collector_if #(
  parameter int unsigned NUM_LANES  = 20,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TS_W   = 32;

  logic [NUM_LANES-1:0] done;
  logic [NUM_LANES-1:0] predicted_class;
  logic                 clear;
  logic                 rd_en;

  logic                 rd_valid;
  logic [LANE_W-1:0]    rd_lane;
  logic                 rd_class;
  logic [TS_W-1:0]      rd_timestamp;
  logic [OCC_W-1:0]     fifo_count;
  logic                 full;
  logic [NUM_LANES-1:0] pending_mask;
  logic [CNT_W-1:0]     count_class0;
  logic [CNT_W-1:0]     count_class1;
  logic                 overflow;

  modport master (
    output done, predicted_class, clear, rd_en,
    input  rd_valid, rd_lane, rd_class, rd_timestamp, fifo_count, full,
           pending_mask, count_class0, count_class1, overflow
  );

  modport slave (
    input  done, predicted_class, clear, rd_en,
    output rd_valid, rd_lane, rd_class, rd_timestamp, fifo_count, full,
           pending_mask, count_class0, count_class1, overflow
  );
endinterface

// File: rtl/snn_result_collector.sv
// Captures each rising per-lane done once, arbitrates pending lanes round-robin into a FWFT
// result FIFO and keeps saturating per-class tallies. SNN_RESULT_TIMESTAMP_EN adds capture timestamps.
module snn_result_collector #(
  parameter int unsigned NUM_LANES  = 20,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rst,
  snn_result_collector_if.slave bus
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = ADDR_W + 1;
  localparam int unsigned TS_W   = 32;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic              cls;
`ifdef SNN_RESULT_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } rec_t;

  // Registered state
  logic [NUM_LANES-1:0] done_q;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] pend_class;
  logic [LANE_W-1:0]    rr_ptr;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [OCC_W-1:0]     count;
  logic                 full_q;
  logic [CNT_W-1:0]     cnt0;
  logic [CNT_W-1:0]     cnt1;
  logic                 overflow_q;
  rec_t                 mem [FIFO_DEPTH];

`ifdef SNN_RESULT_TIMESTAMP_EN
  logic [TS_W-1:0]      ts_cnt;
  logic [TS_W-1:0]      pend_ts [NUM_LANES];
`endif

  // Combinational next-state terms
  logic [NUM_LANES-1:0] rise_c;
  logic [NUM_LANES-1:0] capture_c;
  logic [NUM_LANES-1:0] collide_c;
  logic [NUM_LANES-1:0] upper_c;
  logic [NUM_LANES-1:0] grant_oh_c;
  logic [NUM_LANES-1:0] pending_n_c;
  logic [LANE_W-1:0]    grant_c;
  logic [LANE_W-1:0]    rr_next_c;
  logic                 grant_valid_c;
  logic                 rd_valid_c;
  logic                 pop_c;
  logic                 push_c;
  logic [OCC_W-1:0]     count_n_c;
  rec_t                 push_rec_c;
  rec_t                 head_c;

  // A lane already pending cannot take a second result; the newer one is dropped.
  always_comb begin
    rise_c    = bus.done & ~done_q;
    capture_c = rise_c & ~pending;
    collide_c = rise_c & pending;
  end

  // Round-robin: lowest pending lane at or above rr_ptr, else lowest pending lane overall.
  always_comb begin
    upper_c       = '0;
    grant_c       = '0;
    grant_valid_c = |pending;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      upper_c[i] = pending[i] && (i >= int'(rr_ptr));
    end
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (|upper_c) begin
        if (upper_c[i]) grant_c = LANE_W'(i);
      end else if (pending[i]) begin
        grant_c = LANE_W'(i);
      end
    end
    rr_next_c = (32'(grant_c) == NUM_LANES - 1) ? '0 : grant_c + LANE_W'(1);
  end

  // FIFO control; a full FIFO still accepts a push when the head is popped the same cycle.
  always_comb begin
    rd_valid_c = (count != '0);
    pop_c      = bus.rd_en && rd_valid_c && !bus.clear;
    push_c     = grant_valid_c && !bus.clear &&
                 ((count < OCC_W'(FIFO_DEPTH)) || pop_c);

    grant_oh_c = '0;
    if (push_c) grant_oh_c[grant_c] = 1'b1;
    pending_n_c = (pending & ~grant_oh_c) | capture_c;

    case ({push_c, pop_c})
      2'b10:   count_n_c = count + OCC_W'(1);
      2'b01:   count_n_c = count - OCC_W'(1);
      default: count_n_c = count;
    endcase

    push_rec_c      = '0;
    push_rec_c.lane = grant_c;
    push_rec_c.cls  = pend_class[grant_c];
`ifdef SNN_RESULT_TIMESTAMP_EN
    push_rec_c.ts   = pend_ts[grant_c];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= '0;
      pending    <= '0;
      pend_class <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      // Loading done_q keeps lanes already high from retriggering after the clear.
      done_q     <= bus.done;
      pending    <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= bus.done;
      pending    <= pending_n_c;
      pend_class <= (pend_class & ~capture_c) | (bus.predicted_class & capture_c);
      count      <= count_n_c;
      full_q     <= (count_n_c == OCC_W'(FIFO_DEPTH));
      if (|collide_c) overflow_q <= 1'b1;
      if (pop_c) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        rr_ptr <= rr_next_c;
        if (push_rec_c.cls) begin
          if (cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
        end else begin
          if (cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
        end
      end
    end
  end

  // Record storage needs no reset: it is only observed through rd_valid gating.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= push_rec_c;
  end

`ifdef SNN_RESULT_TIMESTAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < int'(NUM_LANES); i++) pend_ts[i] <= '0;
    end else if (bus.clear) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (capture_c[i]) pend_ts[i] <= ts_cnt;
      end
    end
  end
`endif

  assign head_c = mem[rd_ptr];

  assign bus.rd_valid     = rd_valid_c;
  assign bus.rd_lane      = rd_valid_c ? head_c.lane : '0;
  assign bus.rd_class     = rd_valid_c & head_c.cls;
`ifdef SNN_RESULT_TIMESTAMP_EN
  assign bus.rd_timestamp = rd_valid_c ? head_c.ts : '0;
`else
  assign bus.rd_timestamp = TS_W'(0);
`endif
  assign bus.fifo_count   = count;
  assign bus.full         = full_q;
  assign bus.pending_mask = pending;
  assign bus.count_class0 = cnt0;
  assign bus.count_class1 = cnt1;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_snn_result_collector.sv
// Directed bench for snn_result_collector: 20 lanes, 4-entry FIFO, 3-bit tallies (saturate at 7).
module tb_snn_result_collector;
  localparam int unsigned NL    = 20;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  snn_result_collector_if #(.NUM_LANES(NL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) bus ();

  snn_result_collector #(.NUM_LANES(NL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.done = '0; bus.predicted_class = '0; bus.clear = 1'b0; bus.rd_en = 1'b0;
    tick(); tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0d exp 0", bus.rd_valid); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", bus.full); end
    checks++; if (bus.pending_mask !== 20'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", bus.pending_mask); end
    checks++; if (bus.count_class0 !== 3'd0 || bus.count_class1 !== 3'd0) begin errors++; $display("FAIL reset_tallies got %0d/%0d exp 0/0", bus.count_class0, bus.count_class1); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", bus.overflow); end
    checks++; if (bus.rd_lane !== 5'd0 || bus.rd_class !== 1'b0 || bus.rd_timestamp !== 32'd0) begin errors++; $display("FAIL reset_head got lane %0d cls %0d ts %0d exp 0/0/0", bus.rd_lane, bus.rd_class, bus.rd_timestamp); end
    // done already high at release is captured on the first edge
    bus.done[10] = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.pending_mask !== 20'h00400 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL release_capture got pend %h valid %0d exp 00400/0", bus.pending_mask, bus.rd_valid); end
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_lane !== 5'd10 || bus.rd_class !== 1'b0) begin errors++; $display("FAIL release_push got v%0d lane %0d cls %0d exp 1/10/0", bus.rd_valid, bus.rd_lane, bus.rd_class); end
    checks++; if (bus.count_class0 !== 3'd1) begin errors++; $display("FAIL release_tally0 got %0d exp 1", bus.count_class0); end
    pop1();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL release_pop got %0d exp 0", bus.rd_valid); end
    bus.done = '0;
  endtask

  task automatic test_single_lane();
    bus.predicted_class[3] = 1'b1;
    bus.done[3] = 1'b1;
    tick();
    checks++; if (bus.pending_mask !== 20'h00008 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_capture got pend %h valid %0d exp 00008/0", bus.pending_mask, bus.rd_valid); end
    tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_lane !== 5'd3 || bus.rd_class !== 1'b1) begin errors++; $display("FAIL single_record got v%0d lane %0d cls %0d exp 1/3/1", bus.rd_valid, bus.rd_lane, bus.rd_class); end
    checks++; if (bus.count_class1 !== 3'd1 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL single_counts got c1 %0d cnt %0d exp 1/1", bus.count_class1, bus.fifo_count); end
    tick(); tick(); tick();
    checks++; if (bus.fifo_count !== 3'd1 || bus.pending_mask !== 20'h0) begin errors++; $display("FAIL single_held got cnt %0d pend %h exp 1/0", bus.fifo_count, bus.pending_mask); end
    pop1();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %0d exp 0", bus.rd_valid); end
    bus.done = '0; bus.predicted_class = '0;
    tick();
  endtask

  task automatic test_burst();
    logic [4:0] lanes [3];
    logic       cls   [3];
    lanes[0] = 5'd0; lanes[1] = 5'd7; lanes[2] = 5'd19;
    cls[0] = 1'b0; cls[1] = 1'b1; cls[2] = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++; if (bus.count_class0 !== 3'd0 || bus.count_class1 !== 3'd0) begin errors++; $display("FAIL burst_clear got %0d/%0d exp 0/0", bus.count_class0, bus.count_class1); end
    bus.predicted_class = 20'h80080;
    bus.done = 20'h80081;
    tick();
    checks++; if (bus.pending_mask !== 20'h80081) begin errors++; $display("FAIL burst_capture got %h exp 80081", bus.pending_mask); end
    tick();
    checks++; if (bus.fifo_count !== 3'd1 || bus.pending_mask !== 20'h80080) begin errors++; $display("FAIL burst_push1 got cnt %0d pend %h exp 1/80080", bus.fifo_count, bus.pending_mask); end
    tick();
    checks++; if (bus.fifo_count !== 3'd2 || bus.pending_mask !== 20'h80000) begin errors++; $display("FAIL burst_push2 got cnt %0d pend %h exp 2/80000", bus.fifo_count, bus.pending_mask); end
    tick();
    checks++; if (bus.fifo_count !== 3'd3 || bus.pending_mask !== 20'h0) begin errors++; $display("FAIL burst_push3 got cnt %0d pend %h exp 3/0", bus.fifo_count, bus.pending_mask); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (bus.rd_lane !== lanes[j] || bus.rd_class !== cls[j]) begin errors++; $display("FAIL burst_order%0d got lane %0d cls %0d exp %0d/%0d", j, bus.rd_lane, bus.rd_class, lanes[j], cls[j]); end
      pop1();
    end
    checks++; if (bus.count_class0 !== 3'd1 || bus.count_class1 !== 3'd2) begin errors++; $display("FAIL burst_tallies got %0d/%0d exp 1/2", bus.count_class0, bus.count_class1); end
    bus.done = 20'h00022;
    bus.predicted_class = 20'h00020;
    tick(); tick(); tick();
    checks++; if (bus.fifo_count !== 3'd2 || bus.rd_lane !== 5'd1 || bus.rd_class !== 1'b0) begin errors++; $display("FAIL burst2_first got cnt %0d lane %0d cls %0d exp 2/1/0", bus.fifo_count, bus.rd_lane, bus.rd_class); end
    pop1();
    checks++; if (bus.rd_lane !== 5'd5 || bus.rd_class !== 1'b1) begin errors++; $display("FAIL burst2_second got lane %0d cls %0d exp 5/1", bus.rd_lane, bus.rd_class); end
    pop1();
    bus.done = '0; bus.predicted_class = '0;
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.count_class0 !== 3'd2 || bus.count_class1 !== 3'd3) begin errors++; $display("FAIL burst2_end got v%0d %0d/%0d exp 0 2/3", bus.rd_valid, bus.count_class0, bus.count_class1); end
  endtask

  task automatic test_backpressure();
    logic [4:0] lanes [5];
    logic       cls   [5];
    lanes[0] = 5'd9;  lanes[1] = 5'd10; lanes[2] = 5'd11; lanes[3] = 5'd12; lanes[4] = 5'd13;
    cls[0] = 1'b0; cls[1] = 1'b1; cls[2] = 1'b0; cls[3] = 1'b1; cls[4] = 1'b0;
    bus.predicted_class = 20'h01500;
    bus.done = 20'h03F00;
    repeat (6) tick();
    checks++; if (bus.full !== 1'b1 || bus.fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full got full %0d cnt %0d exp 1/4", bus.full, bus.fifo_count); end
    checks++; if (bus.pending_mask !== 20'h03000 || bus.rd_lane !== 5'd8) begin errors++; $display("FAIL bp_pending got pend %h head %0d exp 03000/8", bus.pending_mask, bus.rd_lane); end
    pop1();
    checks++; if (bus.fifo_count !== 3'd4 || bus.full !== 1'b1 || bus.pending_mask !== 20'h02000) begin errors++; $display("FAIL bp_pushpop got cnt %0d full %0d pend %h exp 4/1/02000", bus.fifo_count, bus.full, bus.pending_mask); end
    for (int j = 0; j < 5; j++) begin
      checks++; if (bus.rd_lane !== lanes[j] || bus.rd_class !== cls[j]) begin errors++; $display("FAIL bp_drain%0d got lane %0d cls %0d exp %0d/%0d", j, bus.rd_lane, bus.rd_class, lanes[j], cls[j]); end
      pop1();
    end
    checks++; if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.full !== 1'b0 || bus.pending_mask !== 20'h0) begin errors++; $display("FAIL bp_empty got v%0d cnt %0d full %0d pend %h exp 0/0/0/0", bus.rd_valid, bus.fifo_count, bus.full, bus.pending_mask); end
    checks++; if (bus.overflow !== 1'b0 || bus.count_class0 !== 3'd5 || bus.count_class1 !== 3'd6) begin errors++; $display("FAIL bp_tallies got ovf %0d %0d/%0d exp 0 5/6", bus.overflow, bus.count_class0, bus.count_class1); end
    bus.done = '0; bus.predicted_class = '0;
    tick();
  endtask

  task automatic test_collision();
    logic [4:0] lanes [5];
    logic       cls   [5];
    lanes[0] = 5'd14; lanes[1] = 5'd15; lanes[2] = 5'd16; lanes[3] = 5'd17; lanes[4] = 5'd2;
    cls[0] = 1'b0; cls[1] = 1'b0; cls[2] = 1'b0; cls[3] = 1'b0; cls[4] = 1'b1;
    bus.predicted_class = 20'h00004;
    bus.done = 20'h3C004;
    repeat (5) tick();
    checks++; if (bus.full !== 1'b1 || bus.pending_mask !== 20'h00004 || bus.overflow !== 1'b0) begin errors++; $display("FAIL coll_setup got full %0d pend %h ovf %0d exp 1/00004/0", bus.full, bus.pending_mask, bus.overflow); end
    bus.done[2] = 1'b0; bus.predicted_class[2] = 1'b0;
    tick();
    bus.done[2] = 1'b1;
    tick();
    checks++; if (bus.overflow !== 1'b1 || bus.pending_mask !== 20'h00004) begin errors++; $display("FAIL coll_overflow got ovf %0d pend %h exp 1/00004", bus.overflow, bus.pending_mask); end
    for (int j = 0; j < 5; j++) begin
      checks++; if (bus.rd_lane !== lanes[j] || bus.rd_class !== cls[j]) begin errors++; $display("FAIL coll_drain%0d got lane %0d cls %0d exp %0d/%0d", j, bus.rd_lane, bus.rd_class, lanes[j], cls[j]); end
      pop1();
    end
    checks++; if (bus.overflow !== 1'b1 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL coll_sticky got ovf %0d cnt %0d exp 1/0", bus.overflow, bus.fifo_count); end
    checks++; if (bus.count_class0 !== 3'd7 || bus.count_class1 !== 3'd7) begin errors++; $display("FAIL coll_saturate got %0d/%0d exp 7/7", bus.count_class0, bus.count_class1); end
    bus.done = '0; bus.predicted_class = '0;
    tick();
  endtask

  task automatic test_clear();
    bus.predicted_class[4] = 1'b1;
    bus.done[4] = 1'b1;
    tick(); tick();
    checks++; if (bus.fifo_count !== 3'd1 || bus.overflow !== 1'b1) begin errors++; $display("FAIL clear_setup got cnt %0d ovf %0d exp 1/1", bus.fifo_count, bus.overflow); end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.full !== 1'b0 || bus.pending_mask !== 20'h0) begin errors++; $display("FAIL clear_fifo got v%0d cnt %0d full %0d pend %h exp 0/0/0/0", bus.rd_valid, bus.fifo_count, bus.full, bus.pending_mask); end
    checks++; if (bus.count_class0 !== 3'd0 || bus.count_class1 !== 3'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL clear_status got %0d/%0d ovf %0d exp 0/0/0", bus.count_class0, bus.count_class1, bus.overflow); end
    checks++; if (bus.rd_lane !== 5'd0 || bus.rd_class !== 1'b0) begin errors++; $display("FAIL clear_head got lane %0d cls %0d exp 0/0", bus.rd_lane, bus.rd_class); end
    repeat (3) tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.pending_mask !== 20'h0) begin errors++; $display("FAIL clear_norecapture got cnt %0d pend %h exp 0/0", bus.fifo_count, bus.pending_mask); end
    bus.done[4] = 1'b0;
    tick();
    bus.done[4] = 1'b1;
    tick();
    checks++; if (bus.pending_mask !== 20'h00010) begin errors++; $display("FAIL clear_retoggle got %h exp 00010", bus.pending_mask); end
    tick();
    checks++; if (bus.rd_lane !== 5'd4 || bus.rd_class !== 1'b1 || bus.count_class1 !== 3'd1) begin errors++; $display("FAIL clear_record got lane %0d cls %0d c1 %0d exp 4/1/1", bus.rd_lane, bus.rd_class, bus.count_class1); end
  endtask

  task automatic test_timestamp();
    logic [31:0] exp_ts;
`ifdef SNN_RESULT_TIMESTAMP_EN
    exp_ts = 32'd100;
`else
    exp_ts = 32'd0;
`endif
    rst = 1'b1;
    #1;
    checks++; if (bus.fifo_count !== 3'd0 || bus.rd_valid !== 1'b0 || bus.count_class1 !== 3'd0) begin errors++; $display("FAIL midop_reset got cnt %0d v%0d c1 %0d exp 0/0/0", bus.fifo_count, bus.rd_valid, bus.count_class1); end
    bus.done = '0; bus.predicted_class = '0;
    tick();
    rst = 1'b0;
    repeat (100) tick();
    bus.done[0] = 1'b1;
    tick(); tick();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_lane !== 5'd0) begin errors++; $display("FAIL ts_record got v%0d lane %0d exp 1/0", bus.rd_valid, bus.rd_lane); end
    checks++; if (bus.rd_timestamp !== exp_ts) begin errors++; $display("FAIL ts_value got %0d exp %0d", bus.rd_timestamp, exp_ts); end
    bus.done = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_burst();
    test_backpressure();
    test_collision();
    test_clear();
    test_timestamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snn_result_collector.md
# snn_result_collector

Receiving end of the inference-core start/done handshake. Watches the `done`/`predicted_class` outputs of `NUM_LANES` parallel `snn_fc_top` instances and captures each completed inference exactly once. Queues completions as {lane, class} records in a FIFO for a host or readout block, and keeps running per-class tallies. This moves result collection, done by a bench loop today, into synthesizable logic beside the inference array.

## Interface
- `NUM_LANES`, 20: number of inference cores observed.
- `FIFO_DEPTH`, 32: result FIFO entries; must be a power of two, at least 2.
- `LANE_W`, `$clog2(NUM_LANES)`: lane index width.
- `CNT_W`, 16: class tally width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `done`  in  NUM_LANES  per-lane core done level; bit i is core i.
- `predicted_class`  in  NUM_LANES  per-lane class (0 = Straight, 1 = Turning); valid while the matching `done` bit is high.
- `clear`  in  1  synchronous soft clear.
- `rd_en`  in  1  pop the head record; ignored when `rd_valid`=0.
- `rd_valid`  out  1  FIFO not empty; head record valid.
- `rd_lane`  out  LANE_W  head record lane index.
- `rd_class`  out  1  head record class.
- `rd_timestamp`  out  32  head record capture cycle (see Configuration).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `full`  out  1  occupancy equals FIFO_DEPTH.
- `pending_mask`  out  NUM_LANES  lanes captured but not yet queued.
- `count_class0`, `count_class1`  out  CNT_W  queued results per class, saturating.
- `overflow`  out  1  sticky flag: a result was lost.

## Operation
- Edge detect: `done_q` registers `done`. Lane i completes when `done[i] & ~done_q[i]`. A held-high `done` is captured once.
- Capture: on a completion, set `pending[i]` and latch `predicted_class[i]` into `pend_class[i]` on the same edge.
- Pending collision: a completion on a lane whose `pending` is already set drops the new result and sets `overflow`. The older pending result is kept.
- Arbiter: each cycle, if any `pending` bit is set and a push is allowed, grant the lowest-indexed pending lane at or above `rr_ptr`, wrapping. On that edge:
  - clear `pending[grant]`;
  - push {grant, pend_class[grant]};
  - set `rr_ptr` = (grant+1) mod NUM_LANES.
  - `rr_ptr` resets to 0.
- A lane whose completion edge and grant fall on the same cycle is not eligible; it is granted no earlier than the next cycle.
- Push allowed when `fifo_count` < FIFO_DEPTH, or when `fifo_count` = FIFO_DEPTH and `rd_en` & `rd_valid` in the same cycle. A blocked push leaves the lane pending; nothing is lost.
- FIFO: first-word-fall-through; `rd_*` reflect the head combinationally from storage. Pointers wrap modulo FIFO_DEPTH. Push and pop together leave `fifo_count` unchanged.
- Tallies: on each push, increment `count_class0` or `count_class1` by `pend_class`. Each saturates at 2^CNT_W-1.
- `clear`: empties the FIFO and zeroes pending, tallies, `overflow` and `rr_ptr`. It also loads `done_q` with the current `done` so already-high lanes do not retrigger. While `clear` is high, captures, pushes and pops that cycle are suppressed.

## Timing
- Reset values: `rd_valid`=0, `rd_lane`=0, `rd_class`=0, `rd_timestamp`=0, `fifo_count`=0, `full`=0, `pending_mask`=0, tallies 0, `overflow`=0. `done_q`=0, so a `done` already high at reset release is captured on the first edge.
- Latency: `done[i]` rises before edge k, giving pending at edge k, push at edge k+1, and `rd_valid`=1 after edge k+1. Uncontended latency is 2 cycles.
- Throughput: one push per cycle. With M simultaneous completions, the last is queued M cycles after capture.
- Reset asserted mid-operation clears all state immediately; in-flight results are discarded.

## Configuration
- `SNN_RESULT_TIMESTAMP_EN` defined:
  - a free-running 32-bit cycle counter, reset to 0, wraps at 2^32 and is zeroed by `clear`;
  - the counter value at the capture edge is latched per lane, stored with each FIFO record and presented on `rd_timestamp`.
- `SNN_RESULT_TIMESTAMP_EN` undefined:
  - no counter and no timestamp storage;
  - `rd_timestamp` is tied to 0.

## Test plan
- Single lane: with NUM_LANES=20, raise `done[3]`, `predicted_class[3]`=1 and hold. Expect `rd_valid` 2 cycles later with `rd_lane`=3, `rd_class`=1 and `count_class1`=1. No second record while `done[3]` stays high.
- Burst: raise `done[0]`, `done[7]` and `done[19]` in the same cycle. Records appear in order 0, 7, 19, one per cycle, and `rr_ptr` ends at 0. Then raise `done[5]` and `done[1]`: order is 1, 5.
- Backpressure: FIFO_DEPTH=4, `rd_en`=0, 6 lanes complete. Expect `full`=1, `fifo_count`=4 and `pending_mask` with 2 bits set. Pop one record and push it in the same cycle: count stays 4. Drain all 6 records with no loss and `overflow`=0.
- Collision: hold lane 2 pending while full, then drop and re-raise `done[2]`. Expect `overflow`=1 and the first-latched class delivered.
- Clear: with `done[4]` held high, assert `clear` for 1 cycle. Expect all outputs at reset values and no recapture of lane 4 until `done[4]` toggles.
- Timestamp build: with `SNN_RESULT_TIMESTAMP_EN`, capture lane 0 at cycle 100 after reset. Expect `rd_timestamp`=100. Without the macro, expect `rd_timestamp`=0.
